chan_pipe_bridge: RTL and testbench

Parametrised multi-channel signal bridge. It is the successor to the plain two-wire pass-through connectors.
- Each of CHANNELS independent lanes carries WIDTH-bit data with a valid/ready handshake.
- Each lane has a DEPTH-entry elastic buffer for retiming and decoupling across long routes between core and uncore.
- DEPTH=0 degenerates to pure combinational pass-through.

---
 rtl/chan_pipe_bridge_pkg.sv | 29 ++
 rtl/chan_pipe_fifo.sv | 78 +++++++
 rtl/chan_pipe_bridge.sv | 64 ++++++
 tb/tb_chan_pipe_bridge.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/chan_pipe_bridge_pkg.sv
// Shared constants and helpers for the chan_pipe_bridge lanes.
// Flush support is controlled by the CHAN_PIPE_BRIDGE_FLUSH_EN macro (see chan_pipe_bridge.sv).
package chan_pipe_bridge_pkg;

    localparam int DEPTH_MAX    = 16;
    localparam int CHANNELS_MAX = 8;

    function automatic int cnt_width(input int depth);
        int w;
        w = $clog2(depth + 1);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

    function automatic int ptr_next(input int ptr, input int depth);
        int nxt;
        if (ptr >= depth - 1) begin
            nxt = 0;
        end else begin
            nxt = ptr + 1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/chan_pipe_fifo.sv
// One lane of the bridge: DEPTH-entry circular buffer (DEPTH >= 1) with valid/ready on both sides.
// Outputs are taken from registered state only; flush gates the handshakes and rewinds the pointers.
module chan_pipe_fifo
    import chan_pipe_bridge_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic                            flush,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [WIDTH-1:0]                in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [WIDTH-1:0]                out_data,
    output logic [cnt_width(DEPTH)-1:0]     count
);

    localparam int CW = cnt_width(DEPTH);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    cnt_r;
    logic             full_s;
    logic             empty_s;
    logic             push_s;
    logic             pop_s;

    // Handshake qualifiers derived from registered occupancy, gated by flush.
    always_comb begin
        full_s    = (cnt_r == CW'(DEPTH));
        empty_s   = (cnt_r == {CW{1'b0}});
        in_ready  = !full_s && !flush;
        out_valid = !empty_s && !flush;
        push_s    = in_valid && in_ready;
        pop_s     = out_valid && out_ready;
        out_data  = mem_r[rd_ptr_r];
        count     = cnt_r;
    end

    // Storage, pointers and occupancy; a full lane refuses the push even when popping.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            cnt_r    <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (flush) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            cnt_r    <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= in_data;
                wr_ptr_r        <= PW'(ptr_next(int'(wr_ptr_r), DEPTH));
            end else begin
                wr_ptr_r        <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= PW'(ptr_next(int'(rd_ptr_r), DEPTH));
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   cnt_r <= cnt_r + CW'(1'b1);
                2'b01:   cnt_r <= cnt_r - CW'(1'b1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

endmodule

// File: rtl/chan_pipe_bridge.sv
// Multi-lane valid/ready bridge: one chan_pipe_fifo per lane, or a wire bypass when DEPTH=0.
// Define CHAN_PIPE_BRIDGE_FLUSH_EN to add the per-lane flush input.
module chan_pipe_bridge
    import chan_pipe_bridge_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int WIDTH    = 1,
    parameter int DEPTH    = 2
) (
    input  logic                                  clock,
    input  logic                                  reset_n,
`ifdef CHAN_PIPE_BRIDGE_FLUSH_EN
    input  logic [CHANNELS-1:0]                   flush,
`endif
    input  logic [CHANNELS-1:0]                   in_valid,
    output logic [CHANNELS-1:0]                   in_ready,
    input  logic [CHANNELS*WIDTH-1:0]             in_data,
    output logic [CHANNELS-1:0]                   out_valid,
    input  logic [CHANNELS-1:0]                   out_ready,
    output logic [CHANNELS*WIDTH-1:0]             out_data,
    output logic [CHANNELS*cnt_width(DEPTH)-1:0]  count
);

    localparam int CW = cnt_width(DEPTH);

    logic [CHANNELS-1:0] flush_s;

`ifdef CHAN_PIPE_BRIDGE_FLUSH_EN
    assign flush_s = flush;
`else
    assign flush_s = {CHANNELS{1'b0}};
`endif

    genvar gi;
    generate
        if (DEPTH == 0) begin : g_bypass
            for (gi = 0; gi < CHANNELS; gi++) begin : g_lane
                assign out_valid[gi]                = in_valid[gi] && !flush_s[gi];
                assign in_ready[gi]                 = out_ready[gi] && !flush_s[gi];
                assign out_data[gi*WIDTH +: WIDTH]  = in_data[gi*WIDTH +: WIDTH];
                assign count[gi*CW +: CW]           = {CW{1'b0}};
            end
        end else begin : g_buffered
            for (gi = 0; gi < CHANNELS; gi++) begin : g_lane
                chan_pipe_fifo #(
                    .WIDTH (WIDTH),
                    .DEPTH (DEPTH)
                ) u_fifo (
                    .clock     (clock),
                    .reset_n   (reset_n),
                    .flush     (flush_s[gi]),
                    .in_valid  (in_valid[gi]),
                    .in_ready  (in_ready[gi]),
                    .in_data   (in_data[gi*WIDTH +: WIDTH]),
                    .out_valid (out_valid[gi]),
                    .out_ready (out_ready[gi]),
                    .out_data  (out_data[gi*WIDTH +: WIDTH]),
                    .count     (count[gi*CW +: CW])
                );
            end
        end
    endgenerate

endmodule

// File: tb/tb_chan_pipe_bridge.sv
// Directed bench for chan_pipe_bridge: DEPTH=2, 3, 4 buffered instances and a DEPTH=0 bypass.
// Flush scenarios are exercised only when CHAN_PIPE_BRIDGE_FLUSH_EN is defined.
module tb_chan_pipe_bridge;

    logic clock;
    logic reset_n;
    int   errors;
    int   checks;

    // DEPTH=2, 2 lanes x 8 bits
    logic [1:0]  d2_in_valid, d2_in_ready, d2_out_valid, d2_out_ready;
    logic [15:0] d2_in_data, d2_out_data;
    logic [3:0]  d2_count;
    // DEPTH=3, 1 lane x 8 bits
    logic        d3_in_valid, d3_in_ready, d3_out_valid, d3_out_ready;
    logic [7:0]  d3_in_data, d3_out_data;
    logic [1:0]  d3_count;
    // DEPTH=0 bypass, 2 lanes x 8 bits
    logic [1:0]  d0_in_valid, d0_in_ready, d0_out_valid, d0_out_ready;
    logic [15:0] d0_in_data, d0_out_data;
    logic [1:0]  d0_count;
    // DEPTH=4, 2 lanes x 8 bits
    logic [1:0]  d4_in_valid, d4_in_ready, d4_out_valid, d4_out_ready;
    logic [15:0] d4_in_data, d4_out_data;
    logic [5:0]  d4_count;
`ifdef CHAN_PIPE_BRIDGE_FLUSH_EN
    logic [1:0]  d0_flush, d2_flush, d3_flush, d4_flush;
`endif

    chan_pipe_bridge #(.CHANNELS(2), .WIDTH(8), .DEPTH(2)) u_d2 (
        .clock(clock), .reset_n(reset_n),
`ifdef CHAN_PIPE_BRIDGE_FLUSH_EN
        .flush(d2_flush),
`endif
        .in_valid(d2_in_valid), .in_ready(d2_in_ready), .in_data(d2_in_data),
        .out_valid(d2_out_valid), .out_ready(d2_out_ready), .out_data(d2_out_data),
        .count(d2_count));

    chan_pipe_bridge #(.CHANNELS(1), .WIDTH(8), .DEPTH(3)) u_d3 (
        .clock(clock), .reset_n(reset_n),
`ifdef CHAN_PIPE_BRIDGE_FLUSH_EN
        .flush(d3_flush[0]),
`endif
        .in_valid(d3_in_valid), .in_ready(d3_in_ready), .in_data(d3_in_data),
        .out_valid(d3_out_valid), .out_ready(d3_out_ready), .out_data(d3_out_data),
        .count(d3_count));

    chan_pipe_bridge #(.CHANNELS(2), .WIDTH(8), .DEPTH(0)) u_d0 (
        .clock(clock), .reset_n(reset_n),
`ifdef CHAN_PIPE_BRIDGE_FLUSH_EN
        .flush(d0_flush),
`endif
        .in_valid(d0_in_valid), .in_ready(d0_in_ready), .in_data(d0_in_data),
        .out_valid(d0_out_valid), .out_ready(d0_out_ready), .out_data(d0_out_data),
        .count(d0_count));

    chan_pipe_bridge #(.CHANNELS(2), .WIDTH(8), .DEPTH(4)) u_d4 (
        .clock(clock), .reset_n(reset_n),
`ifdef CHAN_PIPE_BRIDGE_FLUSH_EN
        .flush(d4_flush),
`endif
        .in_valid(d4_in_valid), .in_ready(d4_in_ready), .in_data(d4_in_data),
        .out_valid(d4_out_valid), .out_ready(d4_out_ready), .out_data(d4_out_data),
        .count(d4_count));

    // Free-running 10-unit clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one rising edge, then settle just past it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        d2_in_valid = 2'b00; d2_out_ready = 2'b00; d2_in_data = 16'h0000;
        d3_in_valid = 1'b0;  d3_out_ready = 1'b0;  d3_in_data = 8'h00;
        d0_in_valid = 2'b00; d0_out_ready = 2'b00; d0_in_data = 16'h0000;
        d4_in_valid = 2'b00; d4_out_ready = 2'b00; d4_in_data = 16'h0000;
`ifdef CHAN_PIPE_BRIDGE_FLUSH_EN
        d0_flush = 2'b00; d2_flush = 2'b00; d3_flush = 2'b00; d4_flush = 2'b00;
`endif
        #23;
        reset_n = 1'b1;
        #1;
        checks++; if (d2_count !== 4'h0) begin errors++; $display("FAIL reset_d2_count got=%h exp=0", d2_count); end
        checks++; if (d2_out_valid !== 2'b00) begin errors++; $display("FAIL reset_d2_out_valid got=%b exp=00", d2_out_valid); end
        checks++; if (d2_in_ready !== 2'b11) begin errors++; $display("FAIL reset_d2_in_ready got=%b exp=11", d2_in_ready); end
        checks++; if (d2_out_data !== 16'h0000) begin errors++; $display("FAIL reset_d2_out_data got=%h exp=0000", d2_out_data); end
        checks++; if (d3_in_ready !== 1'b1 || d3_out_valid !== 1'b0) begin errors++; $display("FAIL reset_d3 got rdy=%b vld=%b exp rdy=1 vld=0", d3_in_ready, d3_out_valid); end
        checks++; if (d4_in_ready !== 2'b11 || d4_count !== 6'h00) begin errors++; $display("FAIL reset_d4 got rdy=%b cnt=%h exp rdy=11 cnt=0", d4_in_ready, d4_count); end
        tick();
    endtask

    task automatic test_fill_drain();
        d2_out_ready = 2'b00;
        d2_in_valid = 2'b01; d2_in_data = 16'h00A5;
        tick();
        d2_in_data = 16'h003C;
        tick();
        d2_in_valid = 2'b00;
        checks++; if (d2_count[1:0] !== 2'd2) begin errors++; $display("FAIL fill_count0 got=%0d exp=2", d2_count[1:0]); end
        checks++; if (d2_count[3:2] !== 2'd0) begin errors++; $display("FAIL fill_count1 got=%0d exp=0", d2_count[3:2]); end
        checks++; if (d2_in_ready !== 2'b10) begin errors++; $display("FAIL fill_in_ready got=%b exp=10", d2_in_ready); end
        checks++; if (d2_out_data[7:0] !== 8'hA5 || d2_out_valid !== 2'b01) begin errors++; $display("FAIL fill_head got=%h vld=%b exp=a5 vld=01", d2_out_data[7:0], d2_out_valid); end
        d2_out_ready = 2'b01;
        tick();
        checks++; if (d2_out_data[7:0] !== 8'h3C || d2_count[1:0] !== 2'd1) begin errors++; $display("FAIL drain_second got=%h cnt=%0d exp=3c cnt=1", d2_out_data[7:0], d2_count[1:0]); end
        tick();
        checks++; if (d2_count[1:0] !== 2'd0 || d2_out_valid !== 2'b00) begin errors++; $display("FAIL drain_empty got cnt=%0d vld=%b exp cnt=0 vld=00", d2_count[1:0], d2_out_valid); end
        d2_out_ready = 2'b00;
    endtask

    task automatic test_wrap();
        d3_in_valid = 1'b1;
        d3_out_ready = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            d3_in_data = 8'(k);
            #1;
            if (k == 1) begin
                checks++; if (d3_out_valid !== 1'b0) begin errors++; $display("FAIL wrap_first_empty got vld=%b exp=0", d3_out_valid); end
            end else begin
                checks++; if (d3_out_valid !== 1'b1 || d3_out_data !== 8'(k - 1) || d3_count !== 2'd1) begin errors++; $display("FAIL wrap_step%0d got data=%h vld=%b cnt=%0d exp data=%h vld=1 cnt=1", k, d3_out_data, d3_out_valid, d3_count, 8'(k - 1)); end
            end
            tick();
        end
        d3_in_valid = 1'b0;
        #1;
        checks++; if (d3_out_data !== 8'h0A || d3_count !== 2'd1) begin errors++; $display("FAIL wrap_last got data=%h cnt=%0d exp data=0a cnt=1", d3_out_data, d3_count); end
        tick();
        checks++; if (d3_count !== 2'd0 || d3_out_valid !== 1'b0) begin errors++; $display("FAIL wrap_empty got cnt=%0d vld=%b exp cnt=0 vld=0", d3_count, d3_out_valid); end
        d3_out_ready = 1'b0;
    endtask

    task automatic test_full_boundary();
        d2_in_valid = 2'b01; d2_in_data = 16'h0011;
        tick();
        d2_in_data = 16'h0022;
        tick();
        d2_in_data = 16'h0077;
        d2_out_ready = 2'b01;
        #1;
        checks++; if (d2_in_ready[0] !== 1'b0) begin errors++; $display("FAIL full_in_ready got=%b exp=0", d2_in_ready[0]); end
        tick();
        checks++; if (d2_count[1:0] !== 2'd1 || d2_out_data[7:0] !== 8'h22) begin errors++; $display("FAIL full_push_refused got cnt=%0d data=%h exp cnt=1 data=22", d2_count[1:0], d2_out_data[7:0]); end
        checks++; if (d2_in_ready[0] !== 1'b1) begin errors++; $display("FAIL full_ready_back got=%b exp=1", d2_in_ready[0]); end
        d2_out_ready = 2'b00;
        tick();
        d2_in_valid = 2'b00;
        checks++; if (d2_count[1:0] !== 2'd2) begin errors++; $display("FAIL full_push_next got cnt=%0d exp=2", d2_count[1:0]); end
        d2_out_ready = 2'b01;
        tick();
        checks++; if (d2_out_data[7:0] !== 8'h77 || d2_count[1:0] !== 2'd1) begin errors++; $display("FAIL full_late_data got=%h cnt=%0d exp=77 cnt=1", d2_out_data[7:0], d2_count[1:0]); end
        tick();
        d2_out_ready = 2'b00;
        checks++; if (d2_count[1:0] !== 2'd0) begin errors++; $display("FAIL full_drained got cnt=%0d exp=0", d2_count[1:0]); end
    endtask

    task automatic test_depth4();
        d4_out_ready = 2'b00;
        d4_in_valid = 2'b01;
        for (int k = 0; k < 5; k++) begin
            d4_in_data = {8'h00, 8'h41 + 8'(k)};
            tick();
        end
        d4_in_valid = 2'b00;
        checks++; if (d4_count[2:0] !== 3'd4 || d4_in_ready[0] !== 1'b0) begin errors++; $display("FAIL d4_full got cnt=%0d rdy=%b exp cnt=4 rdy=0", d4_count[2:0], d4_in_ready[0]); end
        d4_out_ready = 2'b01;
        for (int k = 0; k < 4; k++) begin
            checks++; if (d4_out_data[7:0] !== 8'h41 + 8'(k)) begin errors++; $display("FAIL d4_order%0d got=%h exp=%h", k, d4_out_data[7:0], 8'h41 + 8'(k)); end
            tick();
        end
        d4_out_ready = 2'b00;
        checks++; if (d4_count[2:0] !== 3'd0 || d4_out_valid[0] !== 1'b0) begin errors++; $display("FAIL d4_drained got cnt=%0d vld=%b exp cnt=0 vld=0", d4_count[2:0], d4_out_valid[0]); end
    endtask

    task automatic test_async_reset();
        d2_in_valid = 2'b01; d2_in_data = 16'h005E;
        tick();
        d2_in_data = 16'h006F;
        tick();
        d2_in_valid = 2'b00;
        checks++; if (d2_count[1:0] !== 2'd2) begin errors++; $display("FAIL areset_pre got cnt=%0d exp=2", d2_count[1:0]); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (d2_out_valid !== 2'b00 || d2_count !== 4'h0) begin errors++; $display("FAIL areset_immediate got vld=%b cnt=%h exp vld=00 cnt=0", d2_out_valid, d2_count); end
        checks++; if (d2_out_data !== 16'h0000 || d2_in_ready !== 2'b11) begin errors++; $display("FAIL areset_outputs got data=%h rdy=%b exp data=0000 rdy=11", d2_out_data, d2_in_ready); end
        #2;
        reset_n = 1'b1;
        d2_out_ready = 2'b01;
        tick();
        checks++; if (d2_out_valid !== 2'b00) begin errors++; $display("FAIL areset_no_ghost got vld=%b exp=00", d2_out_valid); end
        d2_out_ready = 2'b00;
        d2_in_valid = 2'b01; d2_in_data = 16'h0099;
        tick();
        d2_in_valid = 2'b00;
        checks++; if (d2_count[1:0] !== 2'd1 || d2_out_data[7:0] !== 8'h99) begin errors++; $display("FAIL areset_first_push got cnt=%0d data=%h exp cnt=1 data=99", d2_count[1:0], d2_out_data[7:0]); end
        d2_out_ready = 2'b01;
        tick();
        d2_out_ready = 2'b00;
    endtask

    task automatic test_bypass();
        d0_in_valid = 2'b01; d0_in_data = 16'h005A; d0_out_ready = 2'b00;
        #1;
        checks++; if (d0_out_valid !== 2'b01 || d0_out_data[7:0] !== 8'h5A) begin errors++; $display("FAIL bypass_lane0 got vld=%b data=%h exp vld=01 data=5a", d0_out_valid, d0_out_data[7:0]); end
        checks++; if (d0_in_ready !== 2'b00 || d0_count !== 2'b00) begin errors++; $display("FAIL bypass_ready0 got rdy=%b cnt=%b exp rdy=00 cnt=00", d0_in_ready, d0_count); end
        d0_out_ready = 2'b10; d0_in_valid = 2'b10; d0_in_data = 16'hC35A;
        #1;
        checks++; if (d0_in_ready !== 2'b10 || d0_out_valid !== 2'b10 || d0_out_data !== 16'hC35A) begin errors++; $display("FAIL bypass_lane1 got rdy=%b vld=%b data=%h exp rdy=10 vld=10 data=c35a", d0_in_ready, d0_out_valid, d0_out_data); end
        d0_in_valid = 2'b00; d0_out_ready = 2'b00;
        tick();
    endtask

`ifdef CHAN_PIPE_BRIDGE_FLUSH_EN
    task automatic test_flush();
        d4_in_valid = 2'b10;
        for (int k = 0; k < 3; k++) begin
            d4_in_data = {8'h31 + 8'(k), 8'h00};
            tick();
        end
        checks++; if (d4_count[5:3] !== 3'd3) begin errors++; $display("FAIL flush_pre got cnt1=%0d exp=3", d4_count[5:3]); end
        d4_flush = 2'b10; d4_in_data = 16'h4400; d4_out_ready = 2'b10;
        #1;
        checks++; if (d4_out_valid[1] !== 1'b0 || d4_in_ready[1] !== 1'b0) begin errors++; $display("FAIL flush_gate got vld=%b rdy=%b exp vld=0 rdy=0", d4_out_valid[1], d4_in_ready[1]); end
        tick();
        d4_flush = 2'b00; d4_in_valid = 2'b00; d4_out_ready = 2'b00;
        checks++; if (d4_count[5:3] !== 3'd0 || d4_out_valid[1] !== 1'b0) begin errors++; $display("FAIL flush_cleared got cnt1=%0d vld=%b exp cnt1=0 vld=0", d4_count[5:3], d4_out_valid[1]); end
        d4_in_valid = 2'b10; d4_in_data = 16'h5500;
        tick();
        d4_in_valid = 2'b00;
        checks++; if (d4_count[5:3] !== 3'd1 || d4_out_data[15:8] !== 8'h55) begin errors++; $display("FAIL flush_restart got cnt1=%0d data=%h exp cnt1=1 data=55", d4_count[5:3], d4_out_data[15:8]); end
        d0_flush = 2'b01; d0_in_valid = 2'b01; d0_out_ready = 2'b01;
        #1;
        checks++; if (d0_out_valid[0] !== 1'b0 || d0_in_ready[0] !== 1'b0) begin errors++; $display("FAIL flush_bypass got vld=%b rdy=%b exp vld=0 rdy=0", d0_out_valid[0], d0_in_ready[0]); end
        d0_flush = 2'b00; d0_in_valid = 2'b00; d0_out_ready = 2'b00;
        tick();
    endtask
`endif

    // Scenario sequence and summary.
    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_fill_drain();
        test_wrap();
        test_full_boundary();
        test_depth4();
        test_async_reset();
        test_bypass();
`ifdef CHAN_PIPE_BRIDGE_FLUSH_EN
        test_flush();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
